// File: rtl/dac_sample_feeder_if.sv
// Sample-feeder bus: producer write strobe, DAC frame sync, flag clear and buffer status.
interface dac_sample_feeder_if #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LOAD_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic                sync_in;
  logic                clr_flags;
  logic [LOAD_W-1:0]   load;
  logic [DEPTH_LOG2:0] level;
  logic                empty;
  logic                full;
  logic                overflow;
  logic                underrun;

  modport master (
    output wr_data, wr_en, sync_in, clr_flags,
    input  load, level, empty, full, overflow, underrun
  );

  modport slave (
    input  wr_data, wr_en, sync_in, clr_flags,
    output load, level, empty, full, overflow, underrun
  );
endinterface

// File: rtl/dac_sample_feeder.sv
// FIFO between bursty sample producers and the DAC frame; pops one sample per sync rising edge.
// Optional DAC_FEEDER_UNDERRUN_CNT_EN adds a saturating 16-bit failed-pop counter port.
module dac_sample_feeder #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LOAD_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  dac_sample_feeder_if.slave        bus
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]               underrun_cnt
`endif
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam int unsigned PTR_W = DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LOAD_W-1:0] load_q, load_d;
  logic              sync_q, sync_d;
  logic              overflow_q, overflow_d;
  logic              underrun_q, underrun_d;

  logic empty_c, full_c, pop_req_c, pop_ok_c, wr_ok_c, ovf_ev_c, und_ev_c;

  // Status decode and event qualification; a pop on a full FIFO frees the slot the write needs.
  always_comb begin
    empty_c   = (level_q == '0);
    full_c    = (level_q == LVL_W'(DEPTH));
    pop_req_c = bus.sync_in & ~sync_q;
    pop_ok_c  = pop_req_c & ~empty_c;
    wr_ok_c   = bus.wr_en & (~full_c | pop_ok_c);
    ovf_ev_c  = bus.wr_en & full_c & ~pop_ok_c;
    und_ev_c  = pop_req_c & empty_c;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    load_d     = load_q;
    sync_d     = bus.sync_in;
    overflow_d = ovf_ev_c | (overflow_q & ~bus.clr_flags);
    underrun_d = und_ev_c | (underrun_q & ~bus.clr_flags);

    if (wr_ok_c) begin
      mem_d[wr_ptr_q] = bus.wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok_c) begin
      load_d   = LOAD_W'(mem_q[rd_ptr_q]);
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_ok_c && !pop_ok_c) begin
      level_d = level_q + LVL_W'(1);
    end else if (!wr_ok_c && pop_ok_c) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Sample storage carries no reset; validity is tracked by pointers and level.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      load_q     <= '0;
      sync_q     <= 1'b1;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      load_q     <= load_d;
      sync_q     <= sync_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.load     = load_q;
  assign bus.level    = level_q;
  assign bus.empty    = empty_c;
  assign bus.full     = full_c;
  assign bus.overflow = overflow_q;
  assign bus.underrun = underrun_q;

`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // A failed pop in the same cycle as a clear restarts the count at one.
  always_comb begin
    ucnt_d = ucnt_q;
    if (und_ev_c) begin
      if (bus.clr_flags) begin
        ucnt_d = 16'd1;
      end else if (ucnt_q != 16'hFFFF) begin
        ucnt_d = ucnt_q + 16'd1;
      end
    end else if (bus.clr_flags) begin
      ucnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif
endmodule

// File: tb/tb_dac_sample_feeder.sv
// Self-checking bench for dac_sample_feeder: directed table, corner sequences, random vs queue model.
module tb_dac_sample_feeder;
  logic clk;
  logic reset;

  dac_sample_feeder_if #(.DATA_W(8), .LOAD_W(16), .DEPTH_LOG2(4)) bus ();

`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
  dac_sample_feeder dut (.clk(clk), .reset(reset), .bus(bus), .underrun_cnt(underrun_cnt));
`else
  dac_sample_feeder dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model: a plain queue plus the externally visible registers.
  logic [7:0]  m_q [$];
  logic [15:0] m_load;
  logic        m_sync;
  logic        m_ovf;
  logic        m_und;
  int unsigned m_cnt;

  typedef struct {
    logic        we;
    logic [7:0]  wd;
    logic        si;
    logic        cl;
    logic [15:0] exp_load;
    logic [4:0]  exp_level;
    logic        exp_ovf;
    logic        exp_und;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_load = 16'h0;
    m_sync = 1'b1;
    m_ovf  = 1'b0;
    m_und  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic m_update(input logic we, input logic [7:0] wd, input logic si, input logic cl);
    bit pop, pop_ok, ovf_ev, und_ev;
    pop    = si && !m_sync;
    pop_ok = pop && (m_q.size() > 0);
    und_ev = pop && (m_q.size() == 0);
    ovf_ev = we && (m_q.size() == 16) && !pop_ok;
    if (pop_ok) m_load = {8'h00, m_q.pop_front()};
    if (we && !ovf_ev) m_q.push_back(wd);
    m_ovf = ovf_ev || (m_ovf && !cl);
    m_und = und_ev || (m_und && !cl);
    if (und_ev) m_cnt = cl ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
    else if (cl) m_cnt = 0;
    m_sync = si;
  endtask

  task automatic check_all();
    chk("load",     32'(bus.load),     32'(m_load));
    chk("level",    32'(bus.level),    32'(m_q.size()));
    chk("empty",    32'(bus.empty),    32'(m_q.size() == 0));
    chk("full",     32'(bus.full),     32'(m_q.size() == 16));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underrun", 32'(bus.underrun), 32'(m_und));
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
    chk("underrun_cnt", 32'(underrun_cnt), m_cnt);
`endif
  endtask

  task automatic step(input logic we, input logic [7:0] wd, input logic si, input logic cl);
    bus.wr_en     = we;
    bus.wr_data   = wd;
    bus.sync_in   = si;
    bus.clr_flags = cl;
    @(posedge clk);
    #1;
    m_update(we, wd, si, cl);
    check_all();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && m_q.size() > 0; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 16'h0000, 5'd2, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h00A5, 5'd1, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h00A5, 5'd1, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h003C, 5'd0, 1'b0, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h003C, 5'd0, 1'b0, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h003C, 5'd0, 1'b0, 1'b1, 16'd1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h003C, 5'd0, 1'b0, 1'b1, 16'd1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h003C, 5'd0, 1'b0, 1'b1, 16'd2};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h003C, 5'd0, 1'b0, 1'b0, 16'd0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 16'h003C, 5'd0, 1'b0, 1'b1, 16'd1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h003C, 5'd0, 1'b0, 1'b0, 16'd0};

    reset         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_data   = 8'h00;
    bus.sync_in   = 1'b0;
    bus.clr_flags = 1'b0;
    m_reset();
    #20;
    check_all();
    #100 reset = 1'b1;

    // Directed table: basic pops, underrun, clear and set-wins.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].si, vecs[i].cl);
      chk($sformatf("tbl%0d_load", i),  32'(bus.load),     32'(vecs[i].exp_load));
      chk($sformatf("tbl%0d_level", i), 32'(bus.level),    32'(vecs[i].exp_level));
      chk($sformatf("tbl%0d_ovf", i),   32'(bus.overflow), 32'(vecs[i].exp_ovf));
      chk($sformatf("tbl%0d_und", i),   32'(bus.underrun), 32'(vecs[i].exp_und));
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
      chk($sformatf("tbl%0d_cnt", i),   32'(underrun_cnt), 32'(vecs[i].exp_cnt));
`endif
    end

    // Level-high sync produces exactly one pop.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("hold_level", 32'(bus.level), 32'd2);
    chk("hold_load",  32'(bus.load),  32'h0011);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Overfill by one, then drain in order across the pointer wrap.
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 16) chk("full_after16", 32'(bus.full), 32'd1);
    end
    chk("ovf_after17",   32'(bus.overflow), 32'd1);
    chk("level_after17", 32'(bus.level),    32'd16);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("drain_load", 32'(bus.load), 32'(i));
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Full FIFO: write and pop in the same cycle are both accepted.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("fullpop_level", 32'(bus.level),    32'd16);
    chk("fullpop_ovf",   32'(bus.overflow), 32'd0);
    chk("fullpop_load",  32'(bus.load),     32'h0040);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Asynchronous reset mid-stream with level 5 and load 0x77.
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    chk("pre_rst_level", 32'(bus.level), 32'd5);
    chk("pre_rst_load",  32'(bus.load),  32'h0077);
    bus.wr_en   = 1'b0;
    bus.sync_in = 1'b1;
    #20 reset = 1'b0;
    #5;
    chk("async_rst_load",  32'(bus.load),  32'h0000);
    chk("async_rst_level", 32'(bus.level), 32'd0);
    chk("async_rst_empty", 32'(bus.empty), 32'd1);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rel_no_underrun", 32'(bus.underrun), 32'd0);

    // Randomized traffic against the queue model, alternating write pressure.
    for (int i = 0; i < 3000; i++) begin
      int unsigned wp;
      logic si;
      wp = ((i / 300) % 2 == 1) ? 85 : 25;
      si = ($urandom_range(99) < 30) ? ~bus.sync_in : bus.sync_in;
      step(($urandom_range(99) < wp), 8'($urandom), si, ($urandom_range(99) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
